// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side consumer of the asynchronous FIFO, living entirely in the read
//   clock domain. Words are popped through the FIFO read-enable/empty
//   interface into a 2-entry output buffer and presented downstream as a
//   valid/ready stream. The stream is framed into fixed PKT_LEN-word packets
//   with a last flag. Dropping i_Enable stops fetching at the next packet
//   boundary.
//
// Ports
//   i_RD_clk      read-domain clock
//   i_RD_rst      synchronous, active-high reset
//   i_Enable      1 = fetch and stream, 0 = stop at next packet boundary
//   i_FIFO_Empty  FIFO empty flag (already in the read domain)
//   i_FIFO_Data   FIFO head word, valid while i_FIFO_Empty = 0
//   o_FIFO_RD_En  pop strobe; the FIFO advances at the clock edge
//   o_Valid       output word valid
//   o_Data        output word
//   o_Last        o_Data is the final word of a packet
//   i_Ready       downstream accepts the word when o_Valid && i_Ready
//   o_Busy        FSM not idle or buffer not empty
//   o_Pkt_Count   completed packets, wraps modulo 2^CNT_W
module fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             i_RD_clk,
  input  logic             i_RD_rst,
  input  logic             i_Enable,
  input  logic             i_FIFO_Empty,
  input  logic [WIDTH-1:0] i_FIFO_Data,
  output logic             o_FIFO_RD_En,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Last,
  input  logic             i_Ready,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_Pkt_Count
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           state, state_nxt;
  logic [1:0]       occ, occ_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] pkt_cnt;

  // Buffer entries: head drives the outputs, tail holds the second word.
  logic [WIDTH-1:0] head_data_p0, tail_data_p0;
  logic             head_last_p0, tail_last_p0;
  logic             vld_p0;

  logic fetch, fire, pop, pop_last;

  assign vld_p0   = (occ != 2'd0);
  assign fetch    = (state == S_RUN) || (state == S_FINISH);
  assign fire     = vld_p0 && i_Ready;
  // A full buffer can still accept a word when the head leaves this cycle.
  // Pops are suppressed during reset so no FIFO word is lost to the flush.
  assign pop      = fetch && !i_FIFO_Empty && ((occ != 2'd2) || fire) && !i_RD_rst;
  assign pop_last = (idx == IDX_LAST);

  assign o_FIFO_RD_En = pop;
  assign o_Valid      = vld_p0;
  assign o_Data       = vld_p0 ? head_data_p0 : '0;
  assign o_Last       = vld_p0 && head_last_p0;
  assign o_Busy       = (state != S_IDLE) || vld_p0;
  assign o_Pkt_Count  = pkt_cnt;

  always_comb begin
    idx_nxt = idx;
    if (pop) idx_nxt = pop_last ? '0 : idx + IDX_W'(1);
  end

  always_comb begin
    occ_nxt = occ;
    case ({pop, fire})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // The stop decision looks at the index after this cycle's pop, so a pop
  // of the final word together with a disable ends cleanly in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_Enable) state_nxt = S_RUN;
      S_RUN:    if (!i_Enable) state_nxt = (idx_nxt == '0) ? S_IDLE : S_FINISH;
      S_FINISH: if (pop && pop_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_RD_clk) begin
    if (i_RD_rst) begin
      state   <= S_IDLE;
      occ     <= 2'd0;
      idx     <= '0;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      idx   <= idx_nxt;
      if (fire && o_Last) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

  // ---- stage p0: buffer contents (cleared logically through occ) ----
  always_ff @(posedge i_RD_clk) begin
    case ({pop, fire})
      2'b10: begin
        if (occ == 2'd0) begin
          head_data_p0 <= i_FIFO_Data;
          head_last_p0 <= pop_last;
        end else begin
          tail_data_p0 <= i_FIFO_Data;
          tail_last_p0 <= pop_last;
        end
      end
      2'b01: begin
        head_data_p0 <= tail_data_p0;
        head_last_p0 <= tail_last_p0;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          head_data_p0 <= i_FIFO_Data;
          head_last_p0 <= pop_last;
        end else begin
          head_data_p0 <= tail_data_p0;
          head_last_p0 <= tail_last_p0;
          tail_data_p0 <= i_FIFO_Data;
          tail_last_p0 <= pop_last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream (WIDTH=8, PKT_LEN=4, CNT_W=2). A queue
//   models the FIFO contents; every pop pushes the expected {last, data} into
//   a scoreboard that is popped and compared on every output handshake.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst, enable, fifo_empty, ready;
  logic [7:0] fifo_data;
  logic       rd_en, valid, last, busy;
  logic [7:0] data;
  logic [1:0] pkt_count;

  fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4), .CNT_W(2)) dut (
    .i_RD_clk    (clk),
    .i_RD_rst    (rst),
    .i_Enable    (enable),
    .i_FIFO_Empty(fifo_empty),
    .i_FIFO_Data (fifo_data),
    .o_FIFO_RD_En(rd_en),
    .o_Valid     (valid),
    .o_Data      (data),
    .o_Last      (last),
    .i_Ready     (ready),
    .o_Busy      (busy),
    .o_Pkt_Count (pkt_count)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [8:0] sb[$];
  logic [1:0] cnt_log[$];
  logic [1:0] pop_idx;
  logic [1:0] exp_cnt;
  int n_assert, n_fail, cyc, n_pops, n_fires, first_fire, last_fire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_drive();
  endtask

  // One clock: sample handshakes at the falling edge, then apply the FIFO
  // pop just after the rising edge.
  task automatic step();
    logic       pop_s, fire_s, e_last;
    logic [8:0] e;
    e_last = 1'b0;
    e      = '0;
    @(negedge clk);
    pop_s  = rd_en;
    fire_s = valid && ready;
    if (pop_s) check("pop_while_empty", fifo_empty, 0);
    if (fire_s) begin
      n_fires++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
      if (sb.size() == 0) check("fire_without_word", 1, 0);
      else begin
        e      = sb.pop_front();
        e_last = e[8];
        check("out_data", data, e[7:0]);
        check("out_last", last, e[8]);
      end
    end
    if (pop_s && fifo_q.size() > 0) begin
      sb.push_back({pop_idx == 2'd3, fifo_q[0]});
      pop_idx = pop_idx + 2'd1;
      n_pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (e_last) begin
      exp_cnt = exp_cnt + 2'd1;
      cnt_log.push_back(pkt_count);
      check("pkt_count", pkt_count, exp_cnt);
    end
    fifo_drive();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(sb.size() == 0 && valid === 1'b0 && rd_en === 1'b0) && n < max);
    check("drain_done", (sb.size() == 0 && valid === 1'b0) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base_pops, base_fires;
    logic [7:0] held;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    n_assert = 0; n_fail = 0; cyc = 0; n_pops = 0; n_fires = 0;
    first_fire = -1; last_fire = -1; pop_idx = 2'd0; exp_cnt = 2'd0;
    rst = 1'b1; enable = 1'b0; ready = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_count", pkt_count, 0);

    // 1: stream with ready high
    ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    step();
    check("t1_first_pop", rd_en, 1);
    check("t1_not_valid_yet", valid, 0);
    step();
    check("t1_valid_next", valid, 1);
    check("t1_first_data", data, 8'h10);
    base_fires = n_fires;
    first_fire = -1;
    drain(40);
    check("t1_words", n_fires - base_fires, 8);
    check("t1_one_per_cycle", last_fire - first_fire, 7);
    check("t1_count", pkt_count, 2);

    // 2: backpressure
    ready = 1'b0;
    base_pops = n_pops;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    step(); step(); step();
    held = data;
    repeat (7) step();
    check("t2_pops_held", n_pops - base_pops, 2);
    check("t2_rd_en_low", rd_en, 0);
    check("t2_data_stable", data, held);
    check("t2_head", data, 8'h20);
    ready = 1'b1;
    base_fires = n_fires;
    drain(40);
    check("t2_all_words", n_fires - base_fires, 6);
    check("t2_fifo_empty", fifo_q.size(), 0);

    // 3: graceful stop two words into a packet
    enable = 1'b0;
    step();
    base_pops = n_pops;
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
    drain(40);
    repeat (6) step();
    check("t3_pops", n_pops - base_pops, 2);
    check("t3_left_in_fifo", fifo_q.size(), 5);
    check("t3_no_pop_idle", rd_en, 0);
    check("t3_busy_low", busy, 0);

    // 4: gap inside a packet
    fifo_q.delete();
    fifo_drive();
    enable = 1'b1;
    push(8'h40);
    push(8'h41);
    drain(20);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_gap_no_pop", rd_en, 0);
      check("t4_gap_no_valid", valid, 0);
    end
    push(8'h42);
    push(8'h43);
    drain(20);
    check("t4_count", pkt_count, 1);

    // 5: reset mid-packet with a full buffer
    ready = 1'b0;
    base_pops = n_pops;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    repeat (6) step();
    check("t5_pops", n_pops - base_pops, 2);
    check("t5_full_no_pop", rd_en, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", valid, 0);
    check("t5_last", last, 0);
    check("t5_busy", busy, 0);
    check("t5_rd_en", rd_en, 0);
    check("t5_data", data, 0);
    check("t5_count", pkt_count, 0);
    sb.delete();
    pop_idx = 2'd0;
    exp_cnt = 2'd0;
    push(8'h54);
    push(8'h55);
    ready = 1'b1;
    drain(30);
    check("t5_count_after", pkt_count, 1);

    // 6: counter wrap over 5 packets
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    pop_idx = 2'd0;
    exp_cnt = 2'd0;
    cnt_log.delete();
    for (int i = 0; i < 20; i++) push(8'h60 + 8'(i));
    drain(80);
    check("t6_packets", cnt_log.size(), 5);
    if (cnt_log.size() == 5)
      for (int i = 0; i < 5; i++) check("t6_count_seq", cnt_log[i], exp_seq[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
